// File: rtl/signal_filter_pkg.sv
// ============================================================================
// Module      : signal_filter_pkg
// Description : Shared constants and helpers for the button debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package signal_filter_pkg;

  localparam int DEFAULT_CNT_WIDTH = 5;
  localparam int SYNC_STAGES       = 2;

  // Terminal value of a w-bit stability counter (2^w - 1).
  function automatic int unsigned terminal_count(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/filter_sync.sv
// ============================================================================
// Module      : filter_sync
// Description : N-stage flop synchroniser, asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/signal_debounce_filter.sv
// ============================================================================
// Module      : signal_debounce_filter
// Description : Debounce filter; a level is accepted after 2^CNT_WIDTH stable
//               enabled samples. Define FILTER_EDGE_PULSE_EN for a rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_debounce_filter
  import signal_filter_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLOCK_ENABLE,
  input  logic IN_SIGNAL,
`ifdef FILTER_EDGE_PULSE_EN
  output logic OUT_SIGNAL_PULSE,
`endif
  output logic OUT_SIGNAL_ENABLE
);

  localparam logic [CNT_WIDTH-1:0] C_TERM = CNT_WIDTH'(terminal_count(CNT_WIDTH));

  logic                 w_sync;
  logic                 w_diff;
  logic                 w_term;
  logic                 w_accept;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_out;

  filter_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_d     (IN_SIGNAL),
    .o_q     (w_sync)
  );

  assign w_diff   = (w_sync != r_out);
  assign w_term   = (r_cnt == C_TERM);
  assign w_accept = w_diff && CLOCK_ENABLE && w_term;

  // Any sample matching the current output restarts the stability run.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (CLOCK_ENABLE) begin
      if (w_term) begin
        r_out <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign OUT_SIGNAL_ENABLE = r_out;

`ifdef FILTER_EDGE_PULSE_EN
  // High for exactly the first cycle in which the accepted level is 1.
  logic r_pulse;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_accept && w_sync;
    end
  end

  assign OUT_SIGNAL_PULSE = r_pulse;
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

`default_nettype wire

// File: tb/tb_signal_debounce_filter.sv
// ============================================================================
// Module      : tb_signal_debounce_filter
// Description : Directed self-checking bench for signal_debounce_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_debounce_filter;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic ce     = 1'b0;
  logic in_sig = 1'b0;
  logic out_en;
`ifdef FILTER_EDGE_PULSE_EN
  logic out_pulse;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signal_debounce_filter #(
    .CNT_WIDTH (5)
  ) dut (
    .CLK               (clk),
    .RESET_N           (rst_n),
    .CLOCK_ENABLE      (ce),
    .IN_SIGNAL         (in_sig),
`ifdef FILTER_EDGE_PULSE_EN
    .OUT_SIGNAL_PULSE  (out_pulse),
`endif
    .OUT_SIGNAL_ENABLE (out_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic e_out, input logic e_pulse);
    checks++;
    assert (out_en === e_out) else begin
      errors++;
      $error("FAIL %s: observed out=%b expected %b", tag, out_en, e_out);
    end
`ifdef FILTER_EDGE_PULSE_EN
    checks++;
    assert (out_pulse === e_pulse) else begin
      errors++;
      $error("FAIL %s_pulse: observed pulse=%b expected %b", tag, out_pulse, e_pulse);
    end
`else
    if (e_pulse === 1'bx) $display("note: unknown pulse expectation in %s", tag);
`endif
  endtask

  task automatic run(input string tag, input int n, input logic e_out);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, e_out, 1'b0);
    end
  endtask

  initial begin
    // Reset held with input pressed: output must stay low.
    rst_n  = 1'b0;
    in_sig = 1'b1;
    ce     = 1'b1;
    #2;
    chk("reset_state", 1'b0, 1'b0);
    run("reset_hold", 5, 1'b0);

    // Release reset; input already high -> rise after 34 edges.
    rst_n = 1'b1;
    run("rel_wait", 33, 1'b0);
    tick();
    chk("rel_rise", 1'b1, 1'b1);

    // Release the button: falls 34 edges later, no pulse on fall.
    in_sig = 1'b0;
    tick();
    chk("long_e35", 1'b1, 1'b0);
    run("fall_wait", 32, 1'b1);
    tick();
    chk("fall_edge", 1'b0, 1'b0);

    // Short press of 18 edges is rejected.
    in_sig = 1'b1;
    run("short_press", 18, 1'b0);
    in_sig = 1'b0;
    run("short_after", 40, 1'b0);

    // Idle low input from low output.
    run("idle", 34, 1'b0);

    // Glitch: 20 high, 1 low, then high; rise 34 edges after glitch end.
    in_sig = 1'b1;
    run("glitch_pre", 20, 1'b0);
    in_sig = 1'b0;
    run("glitch_low", 1, 1'b0);
    in_sig = 1'b1;
    run("glitch_post", 33, 1'b0);
    tick();
    chk("glitch_rise", 1'b1, 1'b1);

    in_sig = 1'b0;
    run("glitch_fall_wait", 33, 1'b1);
    tick();
    chk("glitch_fall", 1'b0, 1'b0);

    // Enable on every 4th edge: rise after 32 enabled samples (edge 128).
    in_sig = 1'b1;
    for (int j = 1; j <= 128; j++) begin
      ce = ((j % 4) == 0);
      tick();
      chk("ce_gated", (j == 128), (j == 128));
    end
    ce = 1'b1;
    tick();
    chk("ce_after", 1'b1, 1'b0);

    // Asynchronous reset mid-count discards progress and clears output.
    in_sig = 1'b0;
    run("mid_count", 20, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 1'b0);
    tick();
    chk("reset_held", 1'b0, 1'b0);
    rst_n  = 1'b1;
    in_sig = 1'b1;
    run("post_reset_wait", 33, 1'b0);
    tick();
    chk("post_reset_rise", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
